// File: rtl/wt_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wt_mem_arbiter
// Memory-side stage between the write-through I$/D$ and a single downstream
// request port. Round-robin arbitrates I$ and D$ requests into one registered
// request, limits in-flight transactions per source, and routes returns back
// to the originating cache one cycle after they arrive.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   ic_req_i/ic_ack_o/ic_addr_i/ic_tid_i
//                                    I$ request (held until acked)
//   dc_req_i/dc_ack_o/dc_addr_i/dc_we_i/dc_wdata_i/dc_tid_i
//                                    D$ request (held until acked)
//   mem_valid_o/mem_ready_i/mem_src_o/mem_addr_o/mem_we_o/mem_wdata_o/mem_tid_o
//                                    registered downstream request
//   rtrn_valid_i/rtrn_src_i/rtrn_tid_i/rtrn_data_i
//                                    downstream return (no backpressure)
//   ic_rtrn_vld_o/dc_rtrn_vld_o/rtrn_tid_o/rtrn_data_o
//                                    registered return to the caches
//   err_o                            sticky protocol-error flag
//   dbg_state_o                      request register state (0 EMPTY, 1 FULL)
//
// Handshakes: a request moves downstream on a clock edge where
// mem_valid_o && mem_ready_i; mem_valid_o and the payload stay stable until
// then. On the cache side, ic_ack_o/dc_ack_o pulse for the single cycle in
// which the request is captured; the cache drops or replaces req afterwards.
// ---------------------------------------------------------------------------
module wt_mem_arbiter #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ic_req_i,
    output logic                 ic_ack_o,
    input  logic [AddrWidth-1:0] ic_addr_i,
    input  logic [TidWidth-1:0]  ic_tid_i,
    input  logic                 dc_req_i,
    output logic                 dc_ack_o,
    input  logic [AddrWidth-1:0] dc_addr_i,
    input  logic                 dc_we_i,
    input  logic [DataWidth-1:0] dc_wdata_i,
    input  logic [TidWidth-1:0]  dc_tid_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic                 mem_src_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [TidWidth-1:0]  mem_tid_o,
    input  logic                 rtrn_valid_i,
    input  logic                 rtrn_src_i,
    input  logic [TidWidth-1:0]  rtrn_tid_i,
    input  logic [DataWidth-1:0] rtrn_data_i,
    output logic                 ic_rtrn_vld_o,
    output logic                 dc_rtrn_vld_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic [DataWidth-1:0] rtrn_data_o,
    output logic                 err_o,
    output logic                 dbg_state_o
);

    localparam int unsigned        CntWidth = 4;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } req_state_e;

    req_state_e           r_state, w_state_nxt;
    logic                 r_src, r_we;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [TidWidth-1:0]  r_tid;
    logic                 r_rr_dc;            // 1: D$ favoured on a tie
    logic [CntWidth-1:0]  r_ic_cnt, r_dc_cnt;
    logic                 r_ic_rtrn, r_dc_rtrn;
    logic [TidWidth-1:0]  r_rtrn_tid;
    logic [DataWidth-1:0] r_rtrn_data;
    logic                 r_err;

    logic                 w_fire, w_load_ok;
    logic                 w_ic_pend, w_dc_pend;
    logic [CntWidth:0]    w_ic_inflight, w_dc_inflight;
    logic                 w_ic_elig, w_dc_elig;
    logic                 w_grant_ic, w_grant_dc;
    logic                 w_ic_inc, w_ic_dec, w_dc_inc, w_dc_dec;

    assign w_fire = (r_state == ST_FULL) && mem_ready_i;

    // The counters only see transactions that have left the request register,
    // so a request still waiting in the register must count against its source
    // too, otherwise one extra request could slip past the limit.
    assign w_ic_pend     = (r_state == ST_FULL) && !r_src;
    assign w_dc_pend     = (r_state == ST_FULL) &&  r_src;
    assign w_ic_inflight = {1'b0, r_ic_cnt} + {{CntWidth{1'b0}}, w_ic_pend};
    assign w_dc_inflight = {1'b0, r_dc_cnt} + {{CntWidth{1'b0}}, w_dc_pend};
    // Registered counts are used, so a return this cycle frees a slot only
    // from the next cycle on.
    assign w_ic_elig     = ic_req_i && (w_ic_inflight < {1'b0, MaxCnt});
    assign w_dc_elig     = dc_req_i && (w_dc_inflight < {1'b0, MaxCnt});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ic  = 1'b0;
        w_grant_dc  = 1'b0;
        // Load when empty, or when the current entry leaves this very cycle.
        w_load_ok   = (r_state == ST_EMPTY) || mem_ready_i;
        if (w_load_ok) begin
            if (w_ic_elig && w_dc_elig) begin
                w_grant_dc = r_rr_dc;
                w_grant_ic = !r_rr_dc;
            end else begin
                w_grant_ic = w_ic_elig;
                w_grant_dc = w_dc_elig;
            end
        end
        case (r_state)
            ST_EMPTY: if (w_grant_ic || w_grant_dc) w_state_nxt = ST_FULL;
            ST_FULL:  if (mem_ready_i && !(w_grant_ic || w_grant_dc)) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src   <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_tid   <= '0;
            r_rr_dc <= 1'b0;
        end else if (w_grant_ic) begin
            r_src   <= 1'b0;
            r_addr  <= ic_addr_i;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_tid   <= ic_tid_i;
            r_rr_dc <= 1'b1;
        end else if (w_grant_dc) begin
            r_src   <= 1'b1;
            r_addr  <= dc_addr_i;
            r_we    <= dc_we_i;
            r_wdata <= dc_wdata_i;
            r_tid   <= dc_tid_i;
            r_rr_dc <= 1'b0;
        end
    end

    assign w_ic_inc = w_fire && !r_src;
    assign w_dc_inc = w_fire &&  r_src;
    assign w_ic_dec = rtrn_valid_i && !rtrn_src_i;
    assign w_dc_dec = rtrn_valid_i &&  rtrn_src_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ic_cnt <= '0;
            r_dc_cnt <= '0;
        end else begin
            if (w_ic_inc && !w_ic_dec && (r_ic_cnt != MaxCnt)) r_ic_cnt <= r_ic_cnt + 1'b1;
            else if (w_ic_dec && !w_ic_inc && (r_ic_cnt != '0)) r_ic_cnt <= r_ic_cnt - 1'b1;
            if (w_dc_inc && !w_dc_dec && (r_dc_cnt != MaxCnt)) r_dc_cnt <= r_dc_cnt + 1'b1;
            else if (w_dc_dec && !w_dc_inc && (r_dc_cnt != '0)) r_dc_cnt <= r_dc_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ic_rtrn   <= 1'b0;
            r_dc_rtrn   <= 1'b0;
            r_rtrn_tid  <= '0;
            r_rtrn_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ic_rtrn <= rtrn_valid_i && !rtrn_src_i;
            r_dc_rtrn <= rtrn_valid_i &&  rtrn_src_i;
            if (rtrn_valid_i) begin
                r_rtrn_tid  <= rtrn_tid_i;
                r_rtrn_data <= rtrn_data_i;
            end
            if ((w_ic_dec && (r_ic_cnt == '0)) || (w_dc_dec && (r_dc_cnt == '0)) ||
                (mem_ready_i && (r_state == ST_EMPTY))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ic_ack_o      = w_grant_ic;
    assign dc_ack_o      = w_grant_dc;
    assign mem_valid_o   = (r_state == ST_FULL);
    assign mem_src_o     = r_src;
    assign mem_addr_o    = r_addr;
    assign mem_we_o      = r_we;
    assign mem_wdata_o   = r_wdata;
    assign mem_tid_o     = r_tid;
    assign ic_rtrn_vld_o = r_ic_rtrn;
    assign dc_rtrn_vld_o = r_dc_rtrn;
    assign rtrn_tid_o    = r_rtrn_tid;
    assign rtrn_data_o   = r_rtrn_data;
    assign err_o         = r_err;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
module tb_wt_mem_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TW  = 2;
    localparam int MAX = 4;
    localparam int PW  = 1 + AW + 1 + DW + TW;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          ic_req_i, dc_req_i, dc_we_i, mem_ready_i;
    logic [AW-1:0] ic_addr_i, dc_addr_i;
    logic [TW-1:0] ic_tid_i, dc_tid_i, rtrn_tid_i;
    logic [DW-1:0] dc_wdata_i, rtrn_data_i;
    logic          rtrn_valid_i, rtrn_src_i;
    logic          ic_ack_o, dc_ack_o, mem_valid_o, mem_src_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, rtrn_data_o;
    logic [TW-1:0] mem_tid_o, rtrn_tid_o;
    logic          ic_rtrn_vld_o, dc_rtrn_vld_o, err_o, dbg_state_o;

    wt_mem_arbiter #(
        .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MAX)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_addr_i(ic_addr_i), .ic_tid_i(ic_tid_i),
        .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_addr_i(dc_addr_i), .dc_we_i(dc_we_i),
        .dc_wdata_i(dc_wdata_i), .dc_tid_i(dc_tid_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_src_o(mem_src_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_tid_o(mem_tid_o),
        .rtrn_valid_i(rtrn_valid_i), .rtrn_src_i(rtrn_src_i), .rtrn_tid_i(rtrn_tid_i),
        .rtrn_data_i(rtrn_data_i),
        .ic_rtrn_vld_o(ic_rtrn_vld_o), .dc_rtrn_vld_o(dc_rtrn_vld_o),
        .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] dut_payload();
        return {mem_src_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_tid_o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        ic_req_i = 0; ic_addr_i = '0; ic_tid_i = '0;
        dc_req_i = 0; dc_addr_i = '0; dc_we_i = 0; dc_wdata_i = '0; dc_tid_i = '0;
        mem_ready_i = 0;
        rtrn_valid_i = 0; rtrn_src_i = 0; rtrn_tid_i = '0; rtrn_data_i = '0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs",
            {ic_ack_o, dc_ack_o, mem_valid_o, dut_payload(), ic_rtrn_vld_o, dc_rtrn_vld_o,
             rtrn_tid_o, rtrn_data_o, dbg_state_o}, '0);
        chk("reset_err", err_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // ---------------- arbitration vector table ----------------
    typedef struct {
        logic ic_req, dc_req, rdy;
        logic exp_ic_ack, exp_dc_ack, exp_valid, exp_src;
    } vec_t;
    vec_t tbl[10];

    // ---------------- reference model state ----------------
    logic [PW-1:0] exp_q[$];
    logic [TW-1:0] acc_ic[$], acc_dc[$];
    int            infl[2];
    logic          fav_dc, prev_rv, prev_rs;
    logic [TW-1:0] prev_tid;
    logic [DW-1:0] prev_data;

    initial begin
        clear_inputs();

        // Both caches request continuously: I$ first, then strict alternation,
        // until each source has MAX transactions in flight.
        tbl[0] = '{1, 1, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 0, 1, 1, 0};
        tbl[2] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[3] = '{1, 1, 1, 0, 1, 1, 0};
        tbl[4] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[5] = '{1, 1, 1, 0, 1, 1, 0};
        tbl[6] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[7] = '{1, 1, 1, 0, 1, 1, 0};
        tbl[8] = '{1, 1, 1, 0, 0, 1, 1};
        tbl[9] = '{1, 1, 0, 0, 0, 0, 0};

        do_reset();
        ic_addr_i = 64'h8000_0040; dc_addr_i = 64'h1000;
        for (int i = 0; i < 10; i++) begin
            ic_req_i = tbl[i].ic_req; dc_req_i = tbl[i].dc_req; mem_ready_i = tbl[i].rdy;
            @(negedge clk_i);
            chk($sformatf("tbl%0d_ic_ack", i), ic_ack_o, tbl[i].exp_ic_ack);
            chk($sformatf("tbl%0d_dc_ack", i), dc_ack_o, tbl[i].exp_dc_ack);
            chk($sformatf("tbl%0d_valid", i), mem_valid_o, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_dbg", i), dbg_state_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_src", i), mem_src_o, tbl[i].exp_src);
            cyc();
        end
        chk("tbl_err", err_o, 1'b0);

        // Single I$ read with ready held high, return at cycle 5.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            ic_req_i = (c == 0); ic_addr_i = 64'h8000_0040; ic_tid_i = 2'd0;
            mem_ready_i = 1'b1;
            rtrn_valid_i = (c == 5); rtrn_src_i = 1'b0; rtrn_tid_i = 2'd0;
            rtrn_data_i = 64'h1234_5678_9ABC_DEF0;
            @(negedge clk_i);
            if (c == 0) chk("rd_ack", ic_ack_o, 1'b1);
            if (c == 0) chk("rd_valid_c0", mem_valid_o, 1'b0);
            if (c == 1) begin
                chk("rd_valid_c1", mem_valid_o, 1'b1);
                chk("rd_payload", dut_payload(), {1'b0, 64'h8000_0040, 1'b0, 64'h0, 2'd0});
                chk("rd_err_ready_idle", err_o, 1'b1);
            end
            if (c == 2) chk("rd_valid_c2", mem_valid_o, 1'b0);
            if (c == 5 || c == 7) chk("rd_rtrn_quiet", ic_rtrn_vld_o, 1'b0);
            if (c == 6) begin
                chk("rd_rtrn_ic", ic_rtrn_vld_o, 1'b1);
                chk("rd_rtrn_dc", dc_rtrn_vld_o, 1'b0);
                chk("rd_rtrn_data", rtrn_data_o, 64'h1234_5678_9ABC_DEF0);
                chk("rd_rtrn_tid", rtrn_tid_o, 2'd0);
            end
            cyc();
        end

        // D$ write stalled three cycles; a second D$ request waits behind it.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            dc_req_i = (c <= 4);
            if (c == 0) begin
                dc_addr_i = 64'h1000; dc_we_i = 1; dc_wdata_i = 64'hDEAD_BEEF; dc_tid_i = 2'd2;
            end else begin
                dc_addr_i = 64'h2000; dc_we_i = 0; dc_wdata_i = 64'h0; dc_tid_i = 2'd3;
            end
            mem_ready_i = (c == 4) || (c == 5);
            @(negedge clk_i);
            if (c <= 4) chk($sformatf("wr_ack_c%0d", c), dc_ack_o, (c == 0) || (c == 4));
            if (c >= 1 && c <= 4) begin
                chk($sformatf("wr_valid_c%0d", c), mem_valid_o, 1'b1);
                chk($sformatf("wr_payload_c%0d", c), dut_payload(),
                    {1'b1, 64'h1000, 1'b1, 64'hDEAD_BEEF, 2'd2});
            end
            if (c == 5) chk("wr_second", dut_payload(), {1'b1, 64'h2000, 1'b0, 64'h0, 2'd3});
            if (c == 6) chk("wr_drained", mem_valid_o, 1'b0);
            cyc();
        end
        chk("wr_err", err_o, 1'b0);

        // D$ issues five reads with no returns; the fifth waits for a return.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            dc_req_i = (c < 8); dc_addr_i = 64'h3000; dc_we_i = 0; dc_tid_i = 2'd1;
            mem_ready_i = (c >= 1 && c <= 4) || (c == 8);
            rtrn_valid_i = (c == 6); rtrn_src_i = 1'b1; rtrn_tid_i = 2'd1;
            rtrn_data_i = 64'h00C0_FFEE;
            @(negedge clk_i);
            if (c < 8) chk($sformatf("max_ack_c%0d", c), dc_ack_o, (c <= 3) || (c == 7));
            if (c == 7) begin
                chk("max_rtrn_dc", dc_rtrn_vld_o, 1'b1);
                chk("max_rtrn_data", rtrn_data_o, 64'h00C0_FFEE);
            end
            if (c == 8) chk("max_fifth_valid", mem_valid_o, 1'b1);
            cyc();
        end
        chk("max_err", err_o, 1'b0);

        // Return to an idle source sets the sticky error; reset clears it async.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rtrn_valid_i = (c == 0); rtrn_src_i = 1'b0;
            @(negedge clk_i);
            chk($sformatf("err_c%0d", c), err_o, c != 0);
            cyc();
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("err_async_clear", err_o, 1'b0);
        @(posedge clk_i);
        #1;

        // Randomized traffic against the transaction-level model.
        do_reset();
        exp_q.delete(); acc_ic.delete(); acc_dc.delete();
        infl[0] = 0; infl[1] = 0; fav_dc = 0; prev_rv = 0; prev_rs = 0;
        prev_tid = '0; prev_data = '0;
        for (int c = 0; c < 400; c++) begin
            logic e_ic, e_dc, ld, p_ic, p_dc;
            logic [PW-1:0] head;
            // Eligible while acks minus returns for that source is below MAX.
            e_ic = ic_req_i && (infl[0] < MAX);
            e_dc = dc_req_i && (infl[1] < MAX);
            ld   = (exp_q.size() == 0) || mem_ready_i;
            p_ic = ld && e_ic && (!e_dc || !fav_dc);
            p_dc = ld && e_dc && (!e_ic || fav_dc);
            @(negedge clk_i);
            chk("rnd_ic_ack", ic_ack_o, p_ic);
            chk("rnd_dc_ack", dc_ack_o, p_dc);
            chk("rnd_valid", mem_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("rnd_payload", dut_payload(), exp_q[0]);
            chk("rnd_ic_rtrn", ic_rtrn_vld_o, prev_rv && !prev_rs);
            chk("rnd_dc_rtrn", dc_rtrn_vld_o, prev_rv && prev_rs);
            if (prev_rv) chk("rnd_rtrn_payload", {rtrn_tid_o, rtrn_data_o}, {prev_tid, prev_data});
            chk("rnd_err", err_o, 1'b0);
            // Advance the model across the coming edge.
            if ((exp_q.size() != 0) && mem_ready_i) begin
                head = exp_q.pop_front();
                if (head[PW-1]) acc_dc.push_back(head[TW-1:0]);
                else            acc_ic.push_back(head[TW-1:0]);
            end
            if (p_ic) begin
                exp_q.push_back({1'b0, ic_addr_i, 1'b0, {DW{1'b0}}, ic_tid_i});
                infl[0]++; fav_dc = 1;
            end else if (p_dc) begin
                exp_q.push_back({1'b1, dc_addr_i, dc_we_i, dc_wdata_i, dc_tid_i});
                infl[1]++; fav_dc = 0;
            end
            prev_rv = rtrn_valid_i; prev_rs = rtrn_src_i;
            prev_tid = rtrn_tid_i; prev_data = rtrn_data_i;
            if (rtrn_valid_i) infl[rtrn_src_i ? 1 : 0]--;
            cyc();
            // New stimulus for the next cycle.
            if (p_ic) ic_req_i = 0;
            if (p_dc) dc_req_i = 0;
            if (!ic_req_i && ($urandom_range(0, 2) != 0)) begin
                ic_req_i = 1; ic_addr_i = {$urandom, $urandom}; ic_tid_i = TW'($urandom);
            end
            if (!dc_req_i && ($urandom_range(0, 2) != 0)) begin
                dc_req_i = 1; dc_addr_i = {$urandom, $urandom}; dc_we_i = 1'($urandom);
                dc_wdata_i = {$urandom, $urandom}; dc_tid_i = TW'($urandom);
            end
            mem_ready_i = (exp_q.size() != 0) && ($urandom_range(0, 3) != 0);
            rtrn_valid_i = 0;
            if (($urandom_range(0, 2) == 0) && ((acc_ic.size() + acc_dc.size()) != 0)) begin
                rtrn_valid_i = 1;
                if (acc_ic.size() == 0)      rtrn_src_i = 1;
                else if (acc_dc.size() == 0) rtrn_src_i = 0;
                else                         rtrn_src_i = 1'($urandom);
                rtrn_tid_i  = rtrn_src_i ? acc_dc.pop_front() : acc_ic.pop_front();
                rtrn_data_i = {$urandom, $urandom};
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
